// File: rtl/vga_sync_decoder.sv
// Rebuilds pixel coordinates and a data-enable from a sampled VGA hs/vs/blank stream.
// Measures line/frame totals, locks after a measured and a verified frame, and pulses err on timing faults.
module vga_sync_decoder #(
  parameter int PIX_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic             vga_blank_n,
  output logic [PIX_W-1:0] rx_x,
  output logic [PIX_W-1:0] rx_y,
  output logic             rx_valid,
  output logic             frame_start,
  output logic             locked,
  output logic [PIX_W-1:0] h_total,
  output logic [PIX_W-1:0] v_total,
  output logic             err
);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic [PIX_W-1:0] CNT_MAX = '1;
  localparam logic [PIX_W-1:0] CNT_ONE = PIX_W'(1);
  localparam logic [PIX_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  state_t           r_state, w_state_nxt;
  logic             r_smp;
  logic             r_hs, r_vs, r_bl, r_hs_d, r_vs_d, r_bl_d;
  logic [PIX_W-1:0] r_hcnt, r_lcnt, r_xcnt, r_ycnt;
  logic             r_h_have;
  logic             w_hs_fall, w_vs_fall, w_bl_rise, w_bl_fall, w_sat_hit;
  logic [PIX_W-1:0] w_period, w_lcnt_inc, w_x_cur, w_y_base;
  logic             w_err, w_cap_h, w_cap_v;

  // Samples are taken on the pix_en edge and evaluated one clk later while r_smp is set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_smp  <= 1'b0;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_bl   <= 1'b1;
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
      r_bl_d <= 1'b1;
    end else begin
      r_smp <= pix_en;
      if (pix_en) begin
        r_hs_d <= r_hs;
        r_vs_d <= r_vs;
        r_bl_d <= r_bl;
        r_hs   <= vga_hs;
        r_vs   <= vga_vs;
        r_bl   <= vga_blank_n;
      end
    end
  end

  assign w_hs_fall  = r_smp & r_hs_d & ~r_hs;
  assign w_vs_fall  = r_smp & r_vs_d & ~r_vs;
  assign w_bl_rise  = r_smp & ~r_bl_d & r_bl;
  assign w_bl_fall  = r_smp & r_bl_d & ~r_bl;
  assign w_sat_hit  = r_smp & ~w_hs_fall & (r_hcnt == CNT_PRE);
  assign w_period   = r_hcnt + CNT_ONE;
  assign w_lcnt_inc = w_hs_fall ? (r_lcnt + CNT_ONE) : r_lcnt;
  assign w_x_cur    = w_bl_rise ? '0 : r_xcnt;
  assign w_y_base   = w_vs_fall ? '0 : r_ycnt;
  assign locked     = (r_state == LOCKED);

  // The HS period check is evaluated before the VS line check; an error on either wins.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_cap_h     = 1'b0;
    w_cap_v     = 1'b0;
    if (r_smp) begin
      case (r_state)
        SEARCH: begin
          if (w_vs_fall) w_state_nxt = MEASURE;
        end
        MEASURE: begin
          w_err   = (w_hs_fall & r_h_have & (w_period != h_total)) | w_sat_hit;
          w_cap_h = w_hs_fall & ~r_h_have;
          if (w_err) begin
            w_state_nxt = SEARCH;
          end else if (w_vs_fall) begin
            w_cap_v     = 1'b1;
            w_state_nxt = VERIFY;
          end
        end
        VERIFY, LOCKED: begin
          w_err = (w_hs_fall & (w_period != h_total)) | w_sat_hit |
                  (w_vs_fall & (w_lcnt_inc != v_total));
          if (w_err) w_state_nxt = SEARCH;
          else if (w_vs_fall) w_state_nxt = LOCKED;
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SEARCH;
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      rx_valid    <= r_smp & r_bl & (w_state_nxt == LOCKED);
      frame_start <= w_vs_fall & (w_state_nxt == LOCKED);
      err         <= w_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hcnt   <= '0;
      r_lcnt   <= '0;
      r_xcnt   <= '0;
      r_ycnt   <= '0;
      r_h_have <= 1'b0;
      rx_x     <= '0;
      rx_y     <= '0;
      h_total  <= '0;
      v_total  <= '0;
    end else if (r_smp) begin
      r_hcnt   <= w_hs_fall ? '0 : ((r_hcnt == CNT_MAX) ? r_hcnt : w_period);
      r_lcnt   <= w_vs_fall ? '0 : w_lcnt_inc;
      r_ycnt   <= (w_bl_fall && (w_y_base != CNT_MAX)) ? (w_y_base + CNT_ONE) : w_y_base;
      r_h_have <= (r_state == MEASURE) & (r_h_have | w_cap_h);
      if (r_bl) begin
        r_xcnt <= (w_x_cur == CNT_MAX) ? w_x_cur : (w_x_cur + CNT_ONE);
        rx_x   <= w_x_cur;
        rx_y   <= w_y_base;
      end
      if (w_cap_h) h_total <= w_period;
      if (w_cap_v) v_total <= w_lcnt_inc;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder: wide and compact timings, line faults, pix_en stalls, resets.
module tb_vga_sync_decoder;

  logic       clk = 1'b0;
  logic       reset, pix_en, vga_hs, vga_vs, vga_blank_n;
  logic [9:0] rx_x, rx_y, h_total, v_total;
  logic       rx_valid, frame_start, locked, err;

  int checks = 0;
  int errors = 0;
  int H, HA, HST, HSW, V, VA, VST, VSW;
  int vld_n = 0, sum_x = 0, sum_y = 0, err_n = 0, fs_n = 0, last_x = 0, last_y = 0;
  int b_v, b_sx, b_sy, b_e, b_f;

  vga_sync_decoder #(.PIX_W(10)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .rx_x(rx_x), .rx_y(rx_y), .rx_valid(rx_valid),
    .frame_start(frame_start), .locked(locked), .h_total(h_total), .v_total(v_total),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      vld_n  <= vld_n + 1;
      sum_x  <= sum_x + int'(rx_x);
      sum_y  <= sum_y + int'(rx_y);
      last_x <= int'(rx_x);
      last_y <= int'(rx_y);
    end
    if (err) err_n <= err_n + 1;
    if (frame_start) fs_n <= fs_n + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic hs, input logic vs, input logic bl);
    vga_hs = hs; vga_vs = vs; vga_blank_n = bl; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic span(input int l, input int h0, input int h1);
    for (int h = h0; h <= h1; h++)
      pix(!(h < HSW), !(l < VSW), (h >= HST) && (h < HST + HA) && (l >= VST) && (l < VST + VA));
  endtask

  task automatic lines(input int l0, input int l1);
    for (int l = l0; l <= l1; l++) span(l, 0, H - 1);
  endtask

  task automatic frame();
    lines(0, V - 1);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_v = vld_n; b_sx = sum_x; b_sy = sum_y; b_e = err_n; b_f = fs_n;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; pix_en = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_x", int'(rx_x), 0);
    chk("rst_rx_y", int'(rx_y), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_h_total", int'(h_total), 0);
    chk("rst_v_total", int'(v_total), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Wide lines: 800-pixel lines, 640 active, 4 lines per frame with 2 active
    H = 800; HA = 640; HST = 144; HSW = 96; V = 4; VA = 2; VST = 1; VSW = 1;
    frame(); frame(); settle();
    chk("wide_locked_f2", int'(locked), 0);
    chk("wide_h_total", int'(h_total), 800);
    chk("wide_v_total", int'(v_total), 4);
    chk("wide_err_f2", err_n, 0);
    snap(); frame(); settle();
    chk("wide_locked_f3", int'(locked), 1);
    chk("wide_valid_cnt", vld_n - b_v, 1280);
    chk("wide_last_x", last_x, 639);
    chk("wide_last_y", last_y, 1);
    chk("wide_sum_x", sum_x - b_sx, 408960);
    chk("wide_frame_start", fs_n - b_f, 1);

    // Compact timing: active 16x8, h_total 24, v_total 12
    pulse_reset();
    H = 24; HA = 16; HST = 4; HSW = 2; V = 12; VA = 8; VST = 2; VSW = 1;
    snap(); frame(); frame(); settle();
    chk("cmp_locked_f2", int'(locked), 0);
    chk("cmp_h_total", int'(h_total), 24);
    chk("cmp_v_total", int'(v_total), 12);
    snap(); frame(); settle();
    chk("cmp_locked_f3", int'(locked), 1);
    chk("cmp_valid_cnt", vld_n - b_v, 128);
    chk("cmp_last_x", last_x, 15);
    chk("cmp_last_y", last_y, 7);
    chk("cmp_sum_x", sum_x - b_sx, 960);
    chk("cmp_sum_y", sum_y - b_sy, 448);
    chk("cmp_frame_start", fs_n - b_f, 1);
    chk("cmp_err", err_n - b_e, 0);

    // pix_en stall mid-line; inputs wiggle but must be ignored
    snap(); lines(0, 4); span(5, 0, 9); settle();
    chk("stall_pre_cnt", vld_n - b_v, 54);
    chk("stall_pre_x", int'(rx_x), 5);
    chk("stall_pre_y", int'(rx_y), 3);
    vga_hs = 1'b0; vga_vs = 1'b0; vga_blank_n = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("stall_cnt", vld_n - b_v, 54);
    chk("stall_x", int'(rx_x), 5);
    chk("stall_y", int'(rx_y), 3);
    chk("stall_locked", int'(locked), 1);
    chk("stall_err", err_n - b_e, 0);
    span(5, 10, 23); lines(6, 11); settle();
    chk("stall_frame_cnt", vld_n - b_v, 128);
    chk("stall_frame_sum_x", sum_x - b_sx, 960);
    chk("stall_frame_err", err_n - b_e, 0);

    // One 23-pixel line while locked
    snap(); lines(0, 4); span(5, 0, 22); lines(6, 11); settle();
    chk("short_err_cnt", err_n - b_e, 1);
    chk("short_locked", int'(locked), 0);
    chk("short_h_total", int'(h_total), 24);
    frame(); frame(); settle();
    chk("short_relock_early", int'(locked), 0);
    chk("short_err_after", err_n - b_e, 1);
    snap(); frame(); settle();
    chk("short_relock", int'(locked), 1);
    chk("short_relock_cnt", vld_n - b_v, 128);
    chk("short_relock_fs", fs_n - b_f, 1);

    // Reset mid-frame while locked
    lines(0, 5); settle();
    reset = 1'b0;
    #1;
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_h_total", int'(h_total), 0);
    chk("mid_rst_v_total", int'(v_total), 0);
    chk("mid_rst_rx_x", int'(rx_x), 0);
    chk("mid_rst_rx_y", int'(rx_y), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    lines(6, 11); frame(); frame(); settle();
    chk("mid_rst_locked_early", int'(locked), 0);
    chk("mid_rst_h_rebuilt", int'(h_total), 24);
    chk("mid_rst_v_rebuilt", int'(v_total), 12);
    snap(); frame(); settle();
    chk("mid_rst_relock", int'(locked), 1);
    chk("mid_rst_cnt", vld_n - b_v, 128);

    // HS stuck high during MEASURE: error exactly when hcnt reaches 1023
    pulse_reset();
    snap(); lines(0, 2); settle();
    chk("stuck_h_total", int'(h_total), 24);
    repeat (999) pix(1'b1, 1'b1, 1'b0);
    settle();
    chk("stuck_no_err_yet", err_n - b_e, 0);
    pix(1'b1, 1'b1, 1'b0);
    settle();
    chk("stuck_err_hit", err_n - b_e, 1);
    repeat (100) pix(1'b1, 1'b1, 1'b0);
    settle();
    chk("stuck_err_single", err_n - b_e, 1);
    chk("stuck_h_kept", int'(h_total), 24);
    chk("stuck_v_total", int'(v_total), 0);
    chk("stuck_locked", int'(locked), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
